// File: rtl/clock_set_ctrl_if.sv
// Key inputs, live counter values and controller outputs for clock_set_ctrl.
interface clock_set_ctrl_if;
  localparam int unsigned VAL_W  = 8;
  localparam int unsigned MODE_W = 3;

  logic              key_mode;
  logic              key_inc;
  logic              key_ok;
  logic [VAL_W-1:0]  cur_hour;
  logic [VAL_W-1:0]  cur_min;
  logic [VAL_W-1:0]  cur_sec;
  logic [MODE_W-1:0] mode;
  logic              run_en;
  logic              modify_hour;
  logic              modify_min;
  logic              modify_sec;
  logic [VAL_W-1:0]  modified_value;
  logic [VAL_W-1:0]  edit_val;
  logic              blink;
  logic [VAL_W-1:0]  alarm_hour;
  logic [VAL_W-1:0]  alarm_min;
  logic              alarm_en;
  logic              alarm_match;

  modport master (
    output key_mode, key_inc, key_ok, cur_hour, cur_min, cur_sec,
    input  mode, run_en, modify_hour, modify_min, modify_sec, modified_value,
           edit_val, blink, alarm_hour, alarm_min, alarm_en, alarm_match
  );

  modport slave (
    input  key_mode, key_inc, key_ok, cur_hour, cur_min, cur_sec,
    output mode, run_en, modify_hour, modify_min, modify_sec, modified_value,
           edit_val, blink, alarm_hour, alarm_min, alarm_en, alarm_match
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Mode/setting controller: sequences time setting, alarm editing and blink.
module clock_set_ctrl #(
  parameter int unsigned HOUR_M    = 24,
  parameter int unsigned MIN_M     = 60,
  parameter int unsigned SEC_M     = 60,
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input logic             clk,
  input logic             rst,
  clock_set_ctrl_if.slave bus
);
  localparam int unsigned VAL_W = 8;
  localparam int unsigned DIV_W = $clog2(BLINK_DIV);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    SET_HOUR = 3'd1,
    SET_MIN  = 3'd2,
    SET_SEC  = 3'd3,
    ALM_HOUR = 3'd4,
    ALM_MIN  = 3'd5
  } state_t;

  state_t             state, state_n;
  logic               key_mode_d, key_inc_d, key_ok_d;
  logic               press_mode, press_inc, press_ok, inc_act;
  logic [VAL_W-1:0]   lim_max;
  logic [VAL_W-1:0]   edit_q, edit_n;
  logic [VAL_W-1:0]   mval_q, mval_n;
  logic [VAL_W-1:0]   ahour_q, ahour_n, amin_q, amin_n;
  logic               mod_hour_q, mod_hour_n, mod_min_q, mod_min_n, mod_sec_q, mod_sec_n;
  logic               aen_q, aen_n, match_q, match_n;
  logic               run_en_q, run_en_n, blink_q, blink_n;
  logic [DIV_W-1:0]   div_q, div_n;

  assign bus.mode           = state;
  assign bus.run_en         = run_en_q;
  assign bus.modify_hour    = mod_hour_q;
  assign bus.modify_min     = mod_min_q;
  assign bus.modify_sec     = mod_sec_q;
  assign bus.modified_value = mval_q;
  assign bus.edit_val       = edit_q;
  assign bus.blink          = blink_q;
  assign bus.alarm_hour     = ahour_q;
  assign bus.alarm_min      = amin_q;
  assign bus.alarm_en       = aen_q;
  assign bus.alarm_match    = match_q;

  // Key history keeps sampling through reset so a key held across release is not a press
  always_ff @(posedge clk) begin
    key_mode_d <= bus.key_mode;
    key_inc_d  <= bus.key_inc;
    key_ok_d   <= bus.key_ok;
  end

  // Next-state, commit, edit and blink decode
  always_comb begin
    state_n    = state;
    edit_n     = edit_q;
    mval_n     = '0;
    mod_hour_n = 1'b0;
    mod_min_n  = 1'b0;
    mod_sec_n  = 1'b0;
    ahour_n    = ahour_q;
    amin_n     = amin_q;
    aen_n      = aen_q;
    blink_n    = blink_q;
    div_n      = div_q;

    press_mode = bus.key_mode & ~key_mode_d;
    press_ok   = bus.key_ok & ~key_ok_d;
    press_inc  = bus.key_inc & ~key_inc_d;
    inc_act    = press_inc & ~press_mode & ~press_ok & (state != RUN);

    case (state)
      SET_HOUR, ALM_HOUR: lim_max = VAL_W'(HOUR_M - 1);
      SET_MIN, ALM_MIN:   lim_max = VAL_W'(MIN_M - 1);
      default:            lim_max = VAL_W'(SEC_M - 1);
    endcase

    // Leaving an edit state commits the edited value
    if (press_mode || (press_ok && state != RUN)) begin
      case (state)
        SET_HOUR: begin mod_hour_n = 1'b1; mval_n = edit_q; end
        SET_MIN:  begin mod_min_n  = 1'b1; mval_n = edit_q; end
        SET_SEC:  begin mod_sec_n  = 1'b1; mval_n = edit_q; end
        ALM_HOUR: ahour_n = edit_q;
        ALM_MIN:  amin_n  = edit_q;
        default:  ;
      endcase
    end

    if (press_mode) begin
      case (state)
        RUN:      begin state_n = SET_HOUR; edit_n = bus.cur_hour; end
        SET_HOUR: begin state_n = SET_MIN;  edit_n = bus.cur_min;  end
        SET_MIN:  begin state_n = SET_SEC;  edit_n = bus.cur_sec;  end
        SET_SEC:  begin state_n = ALM_HOUR; edit_n = ahour_q;      end
        ALM_HOUR: begin state_n = ALM_MIN;  edit_n = amin_q;       end
        default:  state_n = RUN;
      endcase
    end else if (press_ok) begin
      if (state == RUN) aen_n = ~aen_q;
      else              state_n = RUN;
    end else if (inc_act) begin
      edit_n = (edit_q >= lim_max) ? '0 : edit_q + VAL_W'(1);
    end

    if (state_n == RUN || press_mode || inc_act) begin
      blink_n = 1'b1;
      div_n   = '0;
    end else if (div_q == DIV_W'(BLINK_DIV - 1)) begin
      blink_n = ~blink_q;
      div_n   = '0;
    end else begin
      div_n = div_q + DIV_W'(1);
    end

    run_en_n = (state_n == RUN) || (state_n == ALM_HOUR) || (state_n == ALM_MIN);
    match_n  = aen_q && !(state == SET_HOUR || state == SET_MIN || state == SET_SEC) &&
               (bus.cur_hour == ahour_q) && (bus.cur_min == amin_q);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      edit_q     <= '0;
      mval_q     <= '0;
      mod_hour_q <= 1'b0;
      mod_min_q  <= 1'b0;
      mod_sec_q  <= 1'b0;
      ahour_q    <= '0;
      amin_q     <= '0;
      aen_q      <= 1'b0;
      match_q    <= 1'b0;
      run_en_q   <= 1'b1;
      blink_q    <= 1'b1;
      div_q      <= '0;
    end else begin
      state      <= state_n;
      edit_q     <= edit_n;
      mval_q     <= mval_n;
      mod_hour_q <= mod_hour_n;
      mod_min_q  <= mod_min_n;
      mod_sec_q  <= mod_sec_n;
      ahour_q    <= ahour_n;
      amin_q     <= amin_n;
      aen_q      <= aen_n;
      match_q    <= match_n;
      run_en_q   <= run_en_n;
      blink_q    <= blink_n;
      div_q      <= div_n;
    end
  end
endmodule
